// File: rtl/scanline_irq_timer.sv
// scanline_irq_timer
//   Scanline IRQ counter in the style of the MMC3, shared by several mappers.
//   The counter is clocked either by filtered PPU A12 edges or by CPU cycles
//   through a prescaler. A12 polarity is selectable. IRQ-at-zero semantics are
//   either old (revA) or new (revB).
//   Everything runs on clk_ppu. CPU register writes arrive as one-cycle strobes.
//
// Ports
//   clk_ppu        sole clock
//   rst_n          asynchronous active-low reset
//   m2_pulse       one-cycle strobe per CPU cycle
//   ppu_a12        PPU address bit 12
//   reg_we         register write strobe
//   reg_sel[2:0]   0 latch, 1 reload, 2 disable/ack, 3 enable, 4 mode
//   reg_data       write data
//   irq            level IRQ request, active high
//   cnt_o          current counter value (debug)
//   reload_pend_o  reload flag (debug)
module scanline_irq_timer #(
    parameter int CNT_WIDTH = 8,
    parameter int FILTER_M2 = 3,
    parameter int PRESCALE  = 4,
    parameter int OLD_IRQ   = 0
) (
    input  logic                 clk_ppu,
    input  logic                 rst_n,
    input  logic                 m2_pulse,
    input  logic                 ppu_a12,
    input  logic                 reg_we,
    input  logic [2:0]           reg_sel,
    input  logic [CNT_WIDTH-1:0] reg_data,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 reload_pend_o
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [3:0]      FILT_MIN = 4'(FILTER_M2);

    logic [CNT_WIDTH-1:0] cnt, latch, cnt_nxt;
    logic                 reload_pend, reload_nxt;
    logic                 irq_q, irq_en, irq_hit;
    logic [1:0]           mode;
    logic [PS_W-1:0]      pre;
    logic [3:0]           filt_cnt;
    logic                 a12_prev;

    logic wr_latch, wr_reload, wr_ack, wr_en, wr_mode;
    logic a12_eff, a12_edge, pre_wrap, clk_evt;

    assign wr_latch  = reg_we && (reg_sel == 3'd0);
    assign wr_reload = reg_we && (reg_sel == 3'd1);
    assign wr_ack    = reg_we && (reg_sel == 3'd2);
    assign wr_en     = reg_we && (reg_sel == 3'd3);
    assign wr_mode   = reg_we && (reg_sel == 3'd4);

    // Falling-edge mode inverts A12 so one rising-edge detector serves both.
    assign a12_eff  = ppu_a12 ^ mode[1];
    assign a12_edge = a12_eff && !a12_prev && (filt_cnt >= FILT_MIN);
    assign pre_wrap = mode[0] && m2_pulse && (pre == PS_LAST);

    // Only the selected source clocks the counter. A reload or mode write in
    // the same cycle swallows the event.
    assign clk_evt = (mode[0] ? pre_wrap : a12_edge) && !wr_reload && !wr_mode;

    always_comb begin
        cnt_nxt    = cnt;
        reload_nxt = reload_pend;
        irq_hit    = 1'b0;
        if (wr_reload) begin
            cnt_nxt    = '0;
            reload_nxt = 1'b1;
        end else if (clk_evt) begin
            if (cnt == '0 || reload_pend) begin
                cnt_nxt    = latch;
                reload_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt - CNT_WIDTH'(1);
            end
            // Old semantics: a zero latch reloading from zero without a
            // pending reload does not re-fire.
            irq_hit = (irq_en || wr_en) && (cnt_nxt == '0) &&
                      ((OLD_IRQ == 0) || (cnt != '0) || reload_pend);
        end
    end

    always_ff @(posedge clk_ppu or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            latch       <= '0;
            reload_pend <= 1'b0;
            irq_q       <= 1'b0;
            irq_en      <= 1'b0;
            mode        <= 2'b00;
            pre         <= '0;
            filt_cnt    <= 4'd0;
            a12_prev    <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            reload_pend <= reload_nxt;
            a12_prev    <= a12_eff;

            if (wr_latch) latch <= reg_data;

            if (wr_ack)     irq_en <= 1'b0;
            else if (wr_en) irq_en <= 1'b1;

            // An acknowledge wins over an event that would set irq.
            if (wr_ack)       irq_q <= 1'b0;
            else if (irq_hit) irq_q <= 1'b1;

            if (wr_mode) mode <= reg_data[1:0];

            if (wr_mode)
                pre <= '0;
            else if (mode[0] && m2_pulse)
                pre <= pre_wrap ? '0 : pre + 1'b1;

            // Low time is measured in CPU cycles and saturates at the threshold.
            if (a12_eff)
                filt_cnt <= 4'd0;
            else if (m2_pulse && filt_cnt < FILT_MIN)
                filt_cnt <= filt_cnt + 4'd1;
        end
    end

    assign irq           = irq_q;
    assign cnt_o         = cnt;
    assign reload_pend_o = reload_pend;

endmodule
